shift_rx: RTL

Serial-in, parallel-out capture block: the receiving end of the `shift_ctrl` serial link. It frames on the `shld` load pulse and samples `sdata` on each rising edge of `serclk` while `shld` is high. Completed words are presented on a parallel port with a valid/ready handshake. It sits downstream of the shift register driven by `shift_ctrl` and feeds parallel words into the core logic.

---
 rtl/shift_rx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/shift_rx.sv
// Serial-in, parallel-out receiver for the shift_ctrl link: frames on shld, samples
// sdata on qualified serclk rises, and presents completed words with valid/ready.
module shift_rx #(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shld,
   input  logic             serclk,
   input  logic             sdata,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic [4:0]       count,
   output logic             overrun,
   output logic             frame_err,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);

   state_t           r_state;
   logic             r_shld_q;
   logic             r_serclk_q;
   logic             r_serclk_qq;
   logic             r_sdata_q;
   logic [WIDTH-2:0] r_sr;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic [4:0]       r_count;
   logic             r_overrun;
   logic             r_frame_err;

   logic             w_rise;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_word;
   logic [WIDTH-2:0] w_sr_next;

   // Handshake: a word is transferred on every clk edge where valid && ready is high;
   // valid drops on that edge unless a new word completes on the same edge.
   assign w_accept = r_valid & ready;
   assign w_rise   = r_serclk_q & ~r_serclk_qq & r_shld_q;
   assign w_last   = (r_count == LAST_CNT);

   // The register only keeps the WIDTH-1 bits already received; the final bit is
   // merged straight into the outgoing word.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_word    = {r_sr, r_sdata_q};
         assign w_sr_next = w_word[WIDTH-2:0];
      end else begin : g_lsb_first
         assign w_word    = {r_sdata_q, r_sr};
         assign w_sr_next = w_word[WIDTH-1:1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_shld_q    <= 1'b0;
         r_serclk_q  <= 1'b0;
         r_serclk_qq <= 1'b0;
         r_sdata_q   <= 1'b0;
         r_sr        <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_count     <= 5'd0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_shld_q    <= shld;
         r_serclk_q  <= serclk;
         r_serclk_qq <= r_serclk_q;
         r_sdata_q   <= sdata;
         r_frame_err <= 1'b0;

         if (w_accept) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (!r_shld_q) begin
                  r_state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               r_count <= 5'd0;
               r_sr    <= '0;
               if (r_shld_q) begin
                  r_state <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               if (!r_shld_q) begin
                  // shld dropping mid-word aborts the frame; the partial word is lost.
                  if (r_count != 5'd0) begin
                     r_frame_err <= 1'b1;
                  end
                  r_count <= 5'd0;
                  r_sr    <= '0;
                  r_state <= ST_LOAD;
               end else if (w_rise) begin
                  if (w_last) begin
                     r_data  <= w_word;
                     r_valid <= 1'b1;
                     r_count <= 5'd0;
                     r_sr    <= '0;
                     r_state <= ST_IDLE;
                     if (r_valid && !ready) begin
                        r_overrun <= 1'b1;
                     end
                  end else begin
                     r_sr    <= w_sr_next;
                     r_count <= r_count + 5'd1;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign count     = r_count;
   assign overrun   = r_overrun;
   assign frame_err = r_frame_err;
   assign dbg_state = r_state;

endmodule
